opacc_pipe: RTL and testbench



---
 rtl/opacc_pipe.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_opacc_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opacc_pipe.sv
// ---------------------------------------------------------------------------
// opacc_pipe -- pipelined outer-product accumulator.
//
// Holds NUM_MREGS accumulator tiles of ML rows x VL columns, ACC_W bits per
// element. An "ab" op computes tile[t] += ai * bi^T through a 2-stage
// pipeline:
//   S1 registers every ai[i]*bi[j] product, widened to ACC_W bits.
//   S2 adds the products into the tile.
// "mv" ops stream rows in and out of a tile (shift) or zero it (clear).
// Each shifted-out row is presented on co with a valid/ready handshake.
//
// Optional build macro:
//   OPACC_SAT_EN  - when defined, the S2 add saturates according to the
//                   op's signedness; otherwise it wraps modulo 2^ACC_W.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ab_valid / ab_ready   outer-product op handshake
//   ab_addr, ab_signed    target tile, signed(1)/unsigned(0) operands
//   ai, bi                column vector (ML elems), row vector (VL elems)
//   mv_valid / mv_ready   move op handshake
//   mv_op, mv_addr        00 shift, 01 clear, 1x no-op; target tile
//   ci                    row shifted into row 0 on a shift
//   co_valid / co_ready   output row handshake
//   co                    row shifted out of row ML-1
//   busy                  bit t set while an ab op for tile t is in S1/S2
// ---------------------------------------------------------------------------
module opacc_pipe #(
  parameter int NUM_MREGS = 4,
  parameter int XLEN      = 8,
  parameter int VL        = 4,
  parameter int ML        = 4,
  parameter int ACC_W     = 32,
  parameter int AW        = $clog2(NUM_MREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ab_valid,
  output logic                 ab_ready,
  input  logic [AW-1:0]        ab_addr,
  input  logic                 ab_signed,
  input  logic [ML*XLEN-1:0]   ai,
  input  logic [VL*XLEN-1:0]   bi,
  input  logic                 mv_valid,
  output logic                 mv_ready,
  input  logic [1:0]           mv_op,
  input  logic [AW-1:0]        mv_addr,
  input  logic [VL*ACC_W-1:0]  ci,
  output logic                 co_valid,
  input  logic                 co_ready,
  output logic [VL*ACC_W-1:0]  co,
  output logic [NUM_MREGS-1:0] busy
);

  typedef logic [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    MV_SHIFT = 2'b00,
    MV_CLEAR = 2'b01,
    MV_RSV0  = 2'b10,
    MV_RSV1  = 2'b11
  } mv_op_e;

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------

  // The operands are extended to 2*XLEN before the multiply. The truncated
  // product is therefore the exact signed or unsigned result. That result is
  // then sign- or zero-extended to the accumulator width.
  function automatic acc_t widen_mul(input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b,
                                     input logic            sgn);
    logic [2*XLEN-1:0] a_w;
    logic [2*XLEN-1:0] b_w;
    logic [2*XLEN-1:0] p;
    a_w = sgn ? (2*XLEN)'($signed(a)) : (2*XLEN)'(a);
    b_w = sgn ? (2*XLEN)'($signed(b)) : (2*XLEN)'(b);
    p   = a_w * b_w;
    return sgn ? ACC_W'($signed(p)) : ACC_W'(p);
  endfunction

`ifdef OPACC_SAT_EN
  // Saturating add.
  // Unsigned ops clamp on carry-out.
  // Signed ops clamp when both operands share a sign and the sum's sign
  // differs from it.
  function automatic acc_t acc_add(input acc_t acc,
                                   input acc_t prod,
                                   input logic sgn);
    logic [ACC_W:0] sum_w;
    acc_t           sum;
    sum_w = {1'b0, acc} + {1'b0, prod};
    sum   = sum_w[ACC_W-1:0];
    if (!sgn) begin
      return sum_w[ACC_W] ? '1 : sum;
    end
    if ((acc[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])) begin
      return acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return sum;
  endfunction
`else
  function automatic acc_t acc_add(input acc_t acc, input acc_t prod);
    return acc + prod;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  acc_t tile_q [NUM_MREGS][ML][VL];
  acc_t tile_d [NUM_MREGS][ML][VL];

  logic          s1_valid_q, s1_valid_d;
  logic [AW-1:0] s1_addr_q,  s1_addr_d;
  acc_t          s1_prod_q [ML][VL];
  acc_t          s1_prod_d [ML][VL];

  logic          s2_valid_q, s2_valid_d;
  logic [AW-1:0] s2_addr_q,  s2_addr_d;
  acc_t          s2_prod_q [ML][VL];
  acc_t          s2_prod_d [ML][VL];

`ifdef OPACC_SAT_EN
  // The products already carry their signedness in the extension.
  // The op's mode is only needed downstream to pick the clamp bounds.
  logic s1_signed_q, s1_signed_d;
  logic s2_signed_q, s2_signed_d;
`endif

  logic                co_valid_q, co_valid_d;
  logic [VL*ACC_W-1:0] co_q,       co_d;

  // -------------------------------------------------------------------------
  // Handshakes and hazard tracking
  // -------------------------------------------------------------------------
  logic [NUM_MREGS-1:0] busy_vec;
  logic                 co_stall;
  logic                 ab_fire;
  logic                 mv_fire;
  logic                 shift_fire;
  logic                 clear_fire;
  mv_op_e               mv_kind;

  assign mv_kind = mv_op_e'(mv_op);

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_vec = '0;
    if (s1_valid_q) busy_vec[s1_addr_q] = 1'b1;
    if (s2_valid_q) busy_vec[s2_addr_q] = 1'b1;
  end

  assign co_stall = co_valid_q && !co_ready;

  // A move to the same tile wins over an ab op.
  // A move waits until its tile has no ab op in flight. The S2
  // read-modify-write and the move can therefore never touch the same tile
  // on the same edge.
  assign ab_ready   = !(mv_valid && (mv_addr == ab_addr));
  assign mv_ready   = !busy_vec[mv_addr] && !(co_stall && (mv_kind == MV_SHIFT));
  assign ab_fire    = ab_valid && ab_ready;
  assign mv_fire    = mv_valid && mv_ready;
  assign shift_fire = mv_fire && (mv_kind == MV_SHIFT);
  assign clear_fire = mv_fire && (mv_kind == MV_CLEAR);

  // -------------------------------------------------------------------------
  // ab pipeline: S1 products, S2 operands for the accumulate
  // -------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = ab_fire;
    s1_addr_d  = s1_addr_q;
    s1_prod_d  = s1_prod_q;
    if (ab_fire) begin
      s1_addr_d = ab_addr;
      for (int i = 0; i < ML; i++) begin
        for (int j = 0; j < VL; j++) begin
          s1_prod_d[i][j] = widen_mul(ai[i*XLEN +: XLEN], bi[j*XLEN +: XLEN], ab_signed);
        end
      end
    end

    s2_valid_d = s1_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_prod_d  = s2_prod_q;
    if (s1_valid_q) begin
      s2_addr_d = s1_addr_q;
      s2_prod_d = s1_prod_q;
    end
  end

`ifdef OPACC_SAT_EN
  always_comb begin
    s1_signed_d = ab_fire    ? ab_signed   : s1_signed_q;
    s2_signed_d = s1_valid_q ? s1_signed_q : s2_signed_q;
  end
`endif

  // -------------------------------------------------------------------------
  // Tile update
  // -------------------------------------------------------------------------
  // S2 reads the live tile value. Back-to-back ops to one tile are spaced a
  // cycle apart in S2, so each op sees the previous op's result without
  // forwarding.
  always_comb begin
    tile_d = tile_q;

    if (s2_valid_q) begin
      for (int i = 0; i < ML; i++) begin
        for (int j = 0; j < VL; j++) begin
`ifdef OPACC_SAT_EN
          tile_d[s2_addr_q][i][j] = acc_add(tile_q[s2_addr_q][i][j], s2_prod_q[i][j],
                                            s2_signed_q);
`else
          tile_d[s2_addr_q][i][j] = acc_add(tile_q[s2_addr_q][i][j], s2_prod_q[i][j]);
`endif
        end
      end
    end

    if (shift_fire) begin
      for (int j = 0; j < VL; j++) begin
        tile_d[mv_addr][0][j] = ci[j*ACC_W +: ACC_W];
      end
      for (int r = 1; r < ML; r++) begin
        for (int j = 0; j < VL; j++) begin
          tile_d[mv_addr][r][j] = tile_q[mv_addr][r-1][j];
        end
      end
    end

    if (clear_fire) begin
      for (int i = 0; i < ML; i++) begin
        for (int j = 0; j < VL; j++) begin
          tile_d[mv_addr][i][j] = '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output row
  // -------------------------------------------------------------------------
  // A shift is never accepted while a beat is stalled. A new beat therefore
  // only ever replaces a row that is being consumed on the same edge, or an
  // empty slot.
  always_comb begin
    co_valid_d = co_valid_q;
    co_d       = co_q;
    if (co_valid_q && co_ready) co_valid_d = 1'b0;
    if (shift_fire) begin
      co_valid_d = 1'b1;
      for (int j = 0; j < VL; j++) begin
        co_d[j*ACC_W +: ACC_W] = tile_q[mv_addr][ML-1][j];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments.
  // Every flop then samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      co_valid_q <= 1'b0;
      co_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      co_valid_q <= co_valid_d;
      co_q       <= co_d;
    end
  end

  // NOTE: the pipeline product registers are left without reset. They are
  // only consumed behind their stage's valid bit. The tile array, by
  // contrast, is architectural state and must read as zero after reset, so
  // it is reset in full below.
  always_ff @(posedge clk) begin
    s1_prod_q <= s1_prod_d;
    s2_prod_q <= s2_prod_d;
  end

`ifdef OPACC_SAT_EN
  always_ff @(posedge clk) begin
    s1_signed_q <= s1_signed_d;
    s2_signed_q <= s2_signed_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_MREGS; t++) begin
        for (int i = 0; i < ML; i++) begin
          for (int j = 0; j < VL; j++) begin
            tile_q[t][i][j] <= '0;
          end
        end
      end
    end else begin
      tile_q <= tile_d;
    end
  end

  assign co_valid = co_valid_q;
  assign co       = co_q;
  assign busy     = busy_vec;

endmodule

// File: tb/tb_opacc_pipe.sv
// ---------------------------------------------------------------------------
// tb_opacc_pipe -- self-checking bench for opacc_pipe.
//
// Stimulus is applied on the falling edge. Accepts are decided from the
// ready outputs sampled 1 ns later.
//
// The reference model is a plain array of tiles, updated in accept order.
// Each accepted shift pushes its expected output row into a queue. A
// separate monitor pops that queue on every consumed co beat and compares.
//
// A second, 16-bit-accumulator instance covers the wrap/saturate behaviour.
// ---------------------------------------------------------------------------
module tb_opacc_pipe;

  logic         clk;
  logic         reset_n;

  logic         ab_valid, ab_ready, ab_signed;
  logic [1:0]   ab_addr;
  logic [31:0]  ai, bi;
  logic         mv_valid, mv_ready;
  logic [1:0]   mv_op, mv_addr;
  logic [127:0] ci;
  logic         co_valid, co_ready;
  logic [127:0] co;
  logic [3:0]   busy;

  logic         s_ab_valid, s_ab_ready, s_ab_signed;
  logic [1:0]   s_ab_addr;
  logic [31:0]  s_ai, s_bi;
  logic         s_mv_valid, s_mv_ready;
  logic [1:0]   s_mv_op, s_mv_addr;
  logic [63:0]  s_ci;
  logic         s_co_valid, s_co_ready;
  logic [63:0]  s_co;
  logic [3:0]   s_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0]  mdl [4][4][4];
  logic [127:0] exp_q [$];

  opacc_pipe u_dut (
    .clk(clk), .reset_n(reset_n),
    .ab_valid(ab_valid), .ab_ready(ab_ready), .ab_addr(ab_addr), .ab_signed(ab_signed),
    .ai(ai), .bi(bi),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_op(mv_op), .mv_addr(mv_addr), .ci(ci),
    .co_valid(co_valid), .co_ready(co_ready), .co(co), .busy(busy)
  );

  opacc_pipe #(.ACC_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n),
    .ab_valid(s_ab_valid), .ab_ready(s_ab_ready), .ab_addr(s_ab_addr),
    .ab_signed(s_ab_signed), .ai(s_ai), .bi(s_bi),
    .mv_valid(s_mv_valid), .mv_ready(s_mv_ready), .mv_op(s_mv_op), .mv_addr(s_mv_addr),
    .ci(s_ci), .co_valid(s_co_valid), .co_ready(s_co_ready), .co(s_co), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_zero();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mdl[t][i][j] = '0;
  endtask

  task automatic model_ab(input logic [1:0] t, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] ae, be;
        int av, bv;
        ae = a[i*8 +: 8];
        be = b[j*8 +: 8];
        av = sgn ? int'($signed(ae)) : int'(ae);
        bv = sgn ? int'($signed(be)) : int'(be);
        mdl[t][i][j] = mdl[t][i][j] + 32'(av * bv);
      end
    end
  endtask

  task automatic model_shift(input logic [1:0] t, input logic [127:0] c_in);
    logic [127:0] row;
    for (int j = 0; j < 4; j++) row[j*32 +: 32] = mdl[t][3][j];
    exp_q.push_back(row);
    for (int r = 3; r > 0; r--)
      for (int j = 0; j < 4; j++) mdl[t][r][j] = mdl[t][r-1][j];
    for (int j = 0; j < 4; j++) mdl[t][0][j] = c_in[j*32 +: 32];
  endtask

  task automatic model_clear(input logic [1:0] t);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mdl[t][i][j] = '0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit abv, input logic [1:0] aa, input bit as_,
                       input logic [31:0] a_in, input logic [31:0] b_in,
                       input bit mvv, input logic [1:0] mo, input logic [1:0] ma,
                       input logic [127:0] c_in, input bit cor,
                       output bit ab_r, output bit mv_r, output bit ab_f, output bit mv_f);
    @(negedge clk);
    ab_valid = abv; ab_addr = aa; ab_signed = as_; ai = a_in; bi = b_in;
    mv_valid = mvv; mv_op = mo; mv_addr = ma; ci = c_in; co_ready = cor;
    #1;
    ab_r = ab_ready;
    mv_r = mv_ready;
    ab_f = abv && ab_r;
    mv_f = mvv && mv_r;
    @(posedge clk);
    if (ab_f) model_ab(aa, as_, a_in, b_in);
    if (mv_f) begin
      if (mo == 2'b00) model_shift(ma, c_in);
      else if (mo == 2'b01) model_clear(ma);
    end
  endtask

  task automatic idle(input int n, input bit cor);
    bit ar, mr, af, mf;
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, cor, ar, mr, af, mf);
  endtask

  task automatic do_move(input logic [1:0] mo, input logic [1:0] t, input logic [127:0] c_in,
                         input bit cor);
    bit ar, mr, af, mf;
    int n;
    n = 0;
    mf = 0;
    while (!mf && n < 10) begin
      cycle(0, 0, 0, 0, 0, 1, mo, t, c_in, cor, ar, mr, af, mf);
      n++;
    end
    check("move_accept", 128'(mf), 128'd1);
  endtask

  task automatic do_ab(input logic [1:0] t, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b);
    bit ar, mr, af, mf;
    cycle(1, t, sgn, a, b, 0, 0, 0, 0, 1, ar, mr, af, mf);
    check("ab_accept", 128'(af), 128'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset_n && co_valid && co_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL co_unexpected: got %h, expected no beat", co);
        end else begin
          check("co_beat", co, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ar, mr, af, mf;
    int blocked;
    logic [127:0] c;
    logic [15:0] sat_exp;

    ab_valid = 0; ab_addr = 0; ab_signed = 0; ai = 0; bi = 0;
    mv_valid = 0; mv_op = 0; mv_addr = 0; ci = 0; co_ready = 1;
    s_ab_valid = 0; s_ab_addr = 0; s_ab_signed = 0; s_ai = 0; s_bi = 0;
    s_mv_valid = 0; s_mv_op = 0; s_mv_addr = 0; s_ci = 0; s_co_ready = 1;
    model_zero();
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1;
    check("rst_co_valid", 128'(co_valid), 128'd0);
    check("rst_co", co, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ab_ready", 128'(ab_ready), 128'd1);
    check("rst_mv_ready", 128'(mv_ready), 128'd1);

    // Async reset while S1 holds an op for tile 0.
    do_ab(2'd0, 0, 32'h04030201, 32'h05050505);
    #1;
    check("busy_s1", 128'(busy[0]), 128'd1);
    ab_valid = 0;
    reset_n = 0;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_co_valid", 128'(co_valid), 128'd0);
    model_zero();
    @(negedge clk);
    reset_n = 1;

    // Shift stream into tile 0: ci row k element j = k*j, then 4 zero shifts.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) c[j*32 +: 32] = 32'(k * j);
      do_move(2'b00, 2'd0, c, 1);
    end
    for (int s = 0; s < 4; s++) begin
      do_move(2'b00, 2'd0, 128'd0, 1);
      if (s == 1) begin
        #1;
        check("stream_row1", co, {32'd3, 32'd2, 32'd1, 32'd0});
      end
    end

    // Unsigned back-to-back accumulate into tile 1.
    for (int k = 0; k < 4; k++) do_ab(2'd1, 0, 32'h04030201, 32'h05040302);
    do_move(2'b00, 2'd1, 128'd0, 1);
    #1;
    check("acc_t1_3_3", 128'(co[127:96]), 128'd80);
    for (int s = 0; s < 3; s++) do_move(2'b00, 2'd1, 128'd0, 1);

    // Signed vs unsigned widening.
    do_move(2'b01, 2'd2, 128'd0, 1);
    do_ab(2'd2, 1, 32'hFFFFFFFF, 32'h02020202);
    do_move(2'b00, 2'd2, 128'd0, 1);
    #1;
    check("signed_prod", 128'(co[31:0]), 128'hFFFFFFFE);
    do_move(2'b01, 2'd2, 128'd0, 1);
    do_ab(2'd2, 0, 32'hFFFFFFFF, 32'h02020202);
    do_move(2'b00, 2'd2, 128'd0, 1);
    #1;
    check("unsigned_prod", 128'(co[31:0]), 128'h000001FE);

    // Hazard: a shift to a tile with an ab op in flight waits for it to drain.
    do_ab(2'd2, 0, 32'h01010101, 32'h03030303);
    cycle(1, 2'd2, 0, 32'h11111111, 32'h11111111, 1, 2'b00, 2'd2, 128'd7, 1, ar, mr, af, mf);
    check("hazard_ab_ready", 128'(ar), 128'd0);
    check("hazard_mv_ready", 128'(mr), 128'd0);
    blocked = 1;
    while (!mf && blocked < 4) begin
      cycle(0, 0, 0, 0, 0, 1, 2'b00, 2'd2, 128'd7, 1, ar, mr, af, mf);
      if (!mf) blocked++;
    end
    check("hazard_mv_drain", 128'(mf), 128'd1);
    check("hazard_wait_le2", 128'(blocked <= 2), 128'd1);

    // Backpressure: with co_ready low, a second shift stalls and co holds.
    idle(2, 1);
    do_move(2'b00, 2'd3, {4{32'hA5A5_0001}}, 0);
    cycle(0, 0, 0, 0, 0, 1, 2'b00, 2'd3, {4{32'h5A5A_0002}}, 0, ar, mr, af, mf);
    check("bp_mv_ready", 128'(mr), 128'd0);
    #1;
    check("bp_co_valid", 128'(co_valid), 128'd1);
    if (exp_q.size() > 0) begin
      check("bp_co_hold", co, exp_q[0]);
    end else begin
      checks++;
      errors++;
      $display("FAIL bp_co_hold: got empty queue, expected one pending beat");
    end
    idle(1, 1);
    do_move(2'b00, 2'd3, {4{32'h5A5A_0002}}, 1);

    // Randomised mix of ab ops, moves and co backpressure.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] mo;
      c  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom(), $urandom(), ($urandom_range(0, 2) == 0), mo,
            2'($urandom_range(0, 3)), c, ($urandom_range(0, 3) != 0), ar, mr, af, mf);
    end

    // Flush every tile so its full contents go through the scoreboard.
    idle(3, 1);
    for (int t = 0; t < 4; t++)
      for (int s = 0; s < 4; s++) do_move(2'b00, 2'(t), 128'd0, 1);
    idle(5, 1);
    check("queue_empty", 128'(exp_q.size()), 128'd0);

    // 16-bit accumulator: signed 127*127 accumulated three times.
`ifdef OPACC_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hBD03;
`endif
    @(negedge clk);
    s_ab_valid = 1; s_ab_signed = 1; s_ab_addr = 0; s_ai = 32'h7F7F7F7F; s_bi = 32'h7F7F7F7F;
    #1;
    check("sat_ab_ready", 128'(s_ab_ready), 128'd1);
    repeat (3) @(negedge clk);
    s_ab_valid = 0;
    s_mv_valid = 1; s_mv_op = 2'b00; s_mv_addr = 0; s_ci = 0; s_co_ready = 0;
    blocked = 0;
    #1;
    while (!s_mv_ready && blocked < 10) begin
      @(negedge clk);
      #1;
      blocked++;
    end
    check("sat_mv_accept", 128'(s_mv_ready), 128'd1);
    @(posedge clk);
    #1;
    s_mv_valid = 0;
    check("sat_co_valid", 128'(s_co_valid), 128'd1);
    check("sat_value", 128'(s_co[15:0]), 128'(sat_exp));
    check("sat_busy_idle", 128'(s_busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
